// File: rtl/vpu_pkg.sv
// vpu_pkg: shared types and constants for the VPU layer scheduler
package vpu_pkg;
  localparam int VPU_LANES = 4;
  localparam int VPU_DW = 16;
  typedef struct packed {
    logic       bias_en;
    logic       lr_en;
    logic [1:0] rsvd;
  } vpu_path_t;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_RUN, S_DONE} sched_state_t;
endpackage

// File: rtl/vpu_sched_if.sv
// vpu_sched_if: unified-buffer read port, one outstanding request at a time
interface vpu_sched_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req;
  logic [AW-1:0] addr;
  logic          gnt;
  logic          valid;
  logic [DW-1:0] data;
  modport master (output req, addr, input gnt, valid, data);
  modport slave (input req, addr, output gnt, valid, data);
endinterface

// File: rtl/vpu_lane_tracker.sv
// vpu_lane_tracker: per-lane row/column position and output-valid count
module vpu_lane_tracker #(
  parameter int ROW_W = 4,
  parameter int COL_W = 3,
  parameter int PROD_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              sa_valid_i,
  input  logic              out_valid_i,
  input  logic [ROW_W-1:0]  rows_i,
  input  logic [COL_W-1:0]  cols_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [COL_W-1:0]  col_ptr_o,
  output logic              finished_o
);
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [PROD_W-1:0] out_q;
  logic              last_row;
  assign last_row = row_q == rows_i - ROW_W'(1);
  assign col_ptr_o = col_q;
  assign finished_o = out_q == prod_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
      out_q <= '0;
    end else if (clr_i) begin
      row_q <= '0;
      col_q <= '0;
      out_q <= '0;
    end else if (en_i) begin
      if (sa_valid_i) begin
        row_q <= last_row ? '0 : row_q + 1'b1;
        // the last column absorbs any surplus input valids
        if (last_row && col_q != cols_i - COL_W'(1)) col_q <= col_q + 1'b1;
      end
      if (out_valid_i && !finished_o) out_q <= out_q + 1'b1;
    end
  end
endmodule

// File: rtl/vpu_sched.sv
// vpu_sched: fetches leak/bias table from UB, then drives VPU config per column until all lanes finish
module vpu_sched
  import vpu_pkg::*;
#(
  parameter int LANES = VPU_LANES,
  parameter int MAX_ROWS = 8,
  parameter int MAX_COLS = 4,
  parameter int UB_ADDR_W = 16,
  parameter int DW = VPU_DW
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [3:0]                      cmd_pathway,
  input  logic [$clog2(MAX_ROWS+1)-1:0]   cmd_rows,
  input  logic [$clog2(MAX_COLS+1)-1:0]   cmd_cols,
  input  logic [UB_ADDR_W-1:0]            cmd_base_addr,
  output logic                            busy,
  output logic                            done,
  vpu_sched_if.master                     ub,
  input  logic                            sa_valid_in_1,
  input  logic                            sa_valid_in_2,
  input  logic                            sa_valid_in_3,
  input  logic                            sa_valid_in_4,
  input  logic                            vpu_valid_out_1,
  input  logic                            vpu_valid_out_2,
  input  logic                            vpu_valid_out_3,
  input  logic                            vpu_valid_out_4,
  output logic [3:0]                      vpu_data_pathway,
  output logic [DW-1:0]                   bias_scalar_out_1,
  output logic [DW-1:0]                   bias_scalar_out_2,
  output logic [DW-1:0]                   bias_scalar_out_3,
  output logic [DW-1:0]                   bias_scalar_out_4,
  output logic [DW-1:0]                   lr_leak_factor_out
);
  localparam int ROW_W = $clog2(MAX_ROWS+1);
  localparam int COL_W = $clog2(MAX_COLS+1);
  localparam int PROD_W = $clog2(MAX_ROWS*MAX_COLS+1);
  localparam int IDX_W = $clog2(MAX_COLS*LANES+1);
  localparam int CI_W = $clog2(MAX_COLS);
  localparam int LI_W = $clog2(LANES);
  sched_state_t      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, km1;
  logic [ROW_W-1:0]  rows_q;
  logic [COL_W-1:0]  cols_q;
  logic [UB_ADDR_W-1:0] base_q;
  vpu_path_t         path_q;
  logic [DW-1:0]     leak_q;
  logic [DW-1:0]     tbl_q [MAX_COLS][LANES];
  logic              done_q, accept, wr, last_word, run;
  logic [PROD_W-1:0] prod;
  logic [CI_W-1:0]   wr_c;
  logic [LI_W-1:0]   wr_l;
  logic [LANES-1:0]  sa_v, vo_v, fin;
  logic [COL_W-1:0]  col_ptr [LANES];
  logic [DW-1:0]     bias [LANES];
  assign sa_v = {sa_valid_in_4, sa_valid_in_3, sa_valid_in_2, sa_valid_in_1};
  assign vo_v = {vpu_valid_out_4, vpu_valid_out_3, vpu_valid_out_2, vpu_valid_out_1};
  assign accept = state_q == S_IDLE && start;
  assign run = state_q == S_RUN;
  assign wr = state_q == S_WAIT && ub.valid && !abort;
  assign last_word = idx_q == IDX_W'(cols_q) * IDX_W'(LANES);
  assign prod = PROD_W'(rows_q) * PROD_W'(cols_q);
  // word k>=1 maps to column (k-1)/LANES, lane (k-1)%LANES
  assign km1 = idx_q - IDX_W'(1);
  assign wr_c = CI_W'(km1 / IDX_W'(LANES));
  assign wr_l = LI_W'(km1 % IDX_W'(LANES));
  assign busy = state_q != S_IDLE;
  assign done = done_q;
  assign ub.req = state_q == S_FETCH;
  assign ub.addr = ub.req ? base_q + UB_ADDR_W'(idx_q) : '0;
  assign vpu_data_pathway = run ? 4'(path_q) : 4'b0;
  assign lr_leak_factor_out = run ? leak_q : '0;
  assign bias_scalar_out_1 = bias[0];
  assign bias_scalar_out_2 = bias[1];
  assign bias_scalar_out_3 = bias[2];
  assign bias_scalar_out_4 = bias[3];
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = !start ? S_IDLE : (cmd_rows == '0 || cmd_cols == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_d = abort ? S_IDLE : ub.gnt ? S_WAIT : S_FETCH;
      S_WAIT:  state_d = abort ? S_IDLE : !ub.valid ? S_WAIT : last_word ? S_RUN : S_FETCH;
      S_RUN:   state_d = abort ? S_IDLE : &fin ? S_DONE : S_RUN;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q <= 1'b0;
      idx_q <= '0;
      rows_q <= '0;
      cols_q <= '0;
      base_q <= '0;
      path_q <= '0;
      leak_q <= '0;
      for (int c = 0; c < MAX_COLS; c++)
        for (int l = 0; l < LANES; l++) tbl_q[c][l] <= '0;
    end else begin
      state_q <= state_d;
      done_q <= state_q == S_DONE && !abort;
      if (accept) begin
        idx_q <= '0;
        rows_q <= cmd_rows;
        cols_q <= cmd_cols;
        base_q <= cmd_base_addr;
        path_q <= vpu_path_t'(cmd_pathway);
      end
      if (wr) begin
        idx_q <= idx_q + 1'b1;
        if (idx_q == '0) leak_q <= ub.data;
        else tbl_q[wr_c][wr_l] <= ub.data;
      end
    end
  end
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vpu_lane_tracker #(.ROW_W(ROW_W), .COL_W(COL_W), .PROD_W(PROD_W)) u_trk (
      .clk(clk),
      .rst(rst),
      .clr_i(accept),
      .en_i(run),
      .sa_valid_i(sa_v[i]),
      .out_valid_i(vo_v[i]),
      .rows_i(rows_q),
      .cols_i(cols_q),
      .prod_i(prod),
      .col_ptr_o(col_ptr[i]),
      .finished_o(fin[i])
    );
    assign bias[i] = run ? tbl_q[CI_W'(col_ptr[i])][i] : '0;
  end
endmodule

// File: tb/tb_vpu_sched.sv
// tb_vpu_sched: table-driven layer runs plus zero-size, abort and async-reset sequences
module tb_vpu_sched;
  typedef struct {
    int r;
    int c;
    logic [3:0] p;
    logic [15:0] base;
    int gd;
    int vd;
    int sk;
    int exp_rd;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0;
  logic [3:0] cmd_pathway = '0;
  logic [3:0] cmd_rows = '0;
  logic [2:0] cmd_cols = '0;
  logic [15:0] cmd_base_addr = '0;
  logic busy, done;
  logic [3:0] sa_v = '0, vo_v = '0, pathway;
  logic [3:0][15:0] bias;
  logic [15:0] leak;
  int total = 0, bad = 0;
  int gdly = 0, vdly = 0, stall = 0, vcnt = 0;
  logic [15:0] hold, vdat, cur_base = '0;
  logic [15:0] log_q [$];
  vec_t v [5];
  vpu_sched_if #(.AW(16), .DW(16)) ub();
  always #5 clk = ~clk;
  vpu_sched #(.LANES(4), .MAX_ROWS(8), .MAX_COLS(4), .UB_ADDR_W(16), .DW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cmd_pathway(cmd_pathway), .cmd_rows(cmd_rows), .cmd_cols(cmd_cols),
    .cmd_base_addr(cmd_base_addr), .busy(busy), .done(done), .ub(ub),
    .sa_valid_in_1(sa_v[0]), .sa_valid_in_2(sa_v[1]), .sa_valid_in_3(sa_v[2]), .sa_valid_in_4(sa_v[3]),
    .vpu_valid_out_1(vo_v[0]), .vpu_valid_out_2(vo_v[1]), .vpu_valid_out_3(vo_v[2]), .vpu_valid_out_4(vo_v[3]),
    .vpu_data_pathway(pathway),
    .bias_scalar_out_1(bias[0]), .bias_scalar_out_2(bias[1]),
    .bias_scalar_out_3(bias[2]), .bias_scalar_out_4(bias[3]),
    .lr_leak_factor_out(leak)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #2;
  endtask
  function automatic logic [15:0] mem(input logic [15:0] a);
    logic [15:0] off;
    off = a - cur_base;
    return off == 16'h0 ? 16'h0040 : off;
  endfunction
  // UB model: grant after gdly stalled cycles, return data vdly cycles after grant
  initial begin
    ub.gnt = 1'b0;
    ub.valid = 1'b0;
    ub.data = '0;
    forever begin
      @(negedge clk);
      ub.valid = 1'b0;
      ub.gnt = 1'b0;
      if (vcnt > 0) begin
        vcnt--;
        if (vcnt == 0) begin
          ub.valid = 1'b1;
          ub.data = vdat;
        end
      end
      if (ub.req && !rst) begin
        chk("no_overlap", 32'(vcnt > 0 || ub.valid), 0);
        if (stall > 0) chk("stall_addr", 32'(ub.addr), 32'(hold));
        else hold = ub.addr;
        if (stall >= gdly) begin
          ub.gnt = 1'b1;
          log_q.push_back(ub.addr);
          vdat = mem(ub.addr);
          vcnt = vdly + 1;
          stall = 0;
        end else stall++;
      end else if (stall > 0) begin
        chk("req_held", 0, 1);
        stall = 0;
      end
    end
  end
  task automatic run_layer(input vec_t t);
    int col, prod;
    bit ok, early;
    gdly = t.gd;
    vdly = t.vd;
    cur_base = t.base;
    log_q.delete();
    cmd_rows = 4'(t.r);
    cmd_cols = 3'(t.c);
    cmd_pathway = t.p;
    cmd_base_addr = t.base;
    start = 1'b1;
    tick();
    start = 1'b0;
    cmd_rows = '0;
    cmd_cols = '0;
    cmd_pathway = '0;
    cmd_base_addr = ~t.base;
    chk("busy_after_start", 32'(busy), 1);
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      if (log_q.size() == t.exp_rd && vcnt == 0) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk("fetch_complete", 32'(ok), 1);
    tick();
    chk("pathway_run", 32'(pathway), 32'(t.p));
    chk("leak_run", 32'(leak), 32'h40);
    for (int k = 0; k < log_q.size(); k++)
      chk("rd_addr", 32'(log_q[k]), 32'(16'(t.base + 16'(k))));
    prod = t.r * t.c;
    for (int n = 0; n < prod + 2; n++) begin
      sa_v = 4'hF;
      #1;
      col = n / t.r;
      if (col > t.c - 1) col = t.c - 1;
      for (int l = 0; l < 4; l++) chk("bias", 32'(bias[l]), 32'(4 * col + l + 1));
      tick();
    end
    sa_v = '0;
    early = 0;
    for (int b = 0; b < prod + t.sk; b++) begin
      if (done) early = 1;
      vo_v[2:0] = (b < prod) ? 3'b111 : 3'b000;
      vo_v[3] = b >= t.sk;
      tick();
    end
    vo_v = '0;
    chk("no_early_done", 32'(early || done), 0);
    tick();
    chk("done_state_busy", 32'(busy), 1);
    chk("done_not_yet", 32'(done), 0);
    tick();
    chk("done_pulse", 32'(done), 1);
    chk("busy_drop", 32'(busy), 0);
    chk("pathway_idle", 32'(pathway), 0);
    chk("bias_idle", 32'(bias[1]), 0);
    chk("leak_idle", 32'(leak), 0);
    tick();
    chk("done_one_cycle", 32'(done), 0);
    chk("read_count", 32'(log_q.size()), 32'(t.exp_rd));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit saw;
    v[0] = '{8, 4, 4'b1100, 16'h0100, 1, 0, 0, 17};
    v[1] = '{8, 4, 4'b1000, 16'h0200, 5, 3, 0, 17};
    v[2] = '{8, 4, 4'b0100, 16'h0300, 0, 0, 6, 17};
    v[3] = '{3, 2, 4'b1100, 16'hFFFE, 2, 1, 2, 9};
    v[4] = '{1, 1, 4'b1111, 16'h0040, 0, 0, 1, 5};
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_req", 32'(ub.req), 0);
    chk("rst_addr", 32'(ub.addr), 0);
    chk("rst_pathway", 32'(pathway), 0);
    chk("rst_bias", 32'(bias), 0);
    chk("rst_leak", 32'(leak), 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) run_layer(v[i]);
    // zero size, with a simultaneous abort that start must override
    log_q.delete();
    cmd_rows = 4'd4;
    cmd_cols = 3'd0;
    cmd_pathway = 4'b1100;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("zero_busy", 32'(busy), 1);
    chk("zero_no_done_yet", 32'(done), 0);
    chk("zero_pathway", 32'(pathway), 0);
    tick();
    chk("zero_done", 32'(done), 1);
    chk("zero_busy_drop", 32'(busy), 0);
    tick();
    chk("zero_no_reads", 32'(log_q.size()), 0);
    // abort while waiting for read data; late return must be dropped
    gdly = 0;
    vdly = 4;
    cur_base = 16'h0500;
    log_q.delete();
    cmd_rows = 4'd2;
    cmd_cols = 3'd1;
    cmd_pathway = 4'b1100;
    cmd_base_addr = 16'h0500;
    start = 1'b1;
    tick();
    start = 1'b0;
    saw = 0;
    for (int k = 0; k < 50 && log_q.size() == 0; k++) tick();
    chk("abort_first_gnt", 32'(log_q.size()), 1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_req", 32'(ub.req), 0);
    chk("abort_pathway", 32'(pathway), 0);
    for (int k = 0; k < 10; k++) begin
      if (done || busy) saw = 1;
      tick();
    end
    chk("abort_no_done", 32'(saw), 0);
    run_layer('{2, 1, 4'b1100, 16'h0500, 0, 0, 0, 5});
    // asynchronous reset in the middle of column 1
    gdly = 0;
    vdly = 0;
    cur_base = 16'h0600;
    log_q.delete();
    cmd_rows = 4'd4;
    cmd_cols = 3'd2;
    cmd_pathway = 4'b1100;
    cmd_base_addr = 16'h0600;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 200 && !(log_q.size() == 9 && vcnt == 0); k++) tick();
    tick();
    for (int n = 0; n < 5; n++) begin
      sa_v = 4'hF;
      tick();
    end
    sa_v = '0;
    chk("mid_bias_col1", 32'(bias[2]), 32'h7);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_pathway", 32'(pathway), 0);
    chk("arst_bias", 32'(bias), 0);
    chk("arst_leak", 32'(leak), 0);
    chk("arst_req", 32'(ub.req), 0);
    tick();
    rst = 1'b0;
    tick();
    run_layer('{4, 2, 4'b1100, 16'h0600, 0, 0, 0, 9});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
